// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serializer slice.
// WIDTH_DEFAULT : default word width, equal to the downstream SIPO width.
// DIR_LEFT/RIGHT: value driven on dir_out (and stored per word) for each
//                 SIPO shift direction.
// state_e       : serializer FSM states.
package nibble_serializer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO buffering {direction, data} words ahead of the
// serializer.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset, empties the FIFO
//   push      : write push_data (ignored while full)
//   push_data : word to store
//   pop       : remove the head entry (ignored while empty)
//   pop_data  : current head entry
//   full      : DEPTH entries stored
//   empty     : no entries stored
module nibble_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap modulo DEPTH, which need not fill the pointer width.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nibble_serializer.sv
// Feeds a WIDTH-bit bidirectional SIPO: accepts words with a direction flag
// over valid/ready, buffers them, and shifts each out one bit per cycle so
// that after WIDTH shifts the SIPO holds the accepted word.
// Ports:
//   clk       : rising-edge clock shared with the SIPO
//   reset     : synchronous active-low reset
//   in_valid  : word offered
//   in_ready  : word can be accepted (combinational: reset & !fifo_full)
//   in_data   : word to serialize
//   in_left   : 1 = SIPO shifts left (MSB sent first), 0 = right (LSB first)
//   ser_out   : serial bit to SIPO din
//   dir_out   : direction to SIPO left; changes only at word boundaries
//   busy      : a word is being shifted
//   word_done : pulse in the cycle the last bit of a word is driven
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_left,
  output logic             ser_out,
  output logic             dir_out,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             dir_out_q, dir_out_d;
  logic             busy_q, busy_d;
  logic             word_done_q, word_done_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, load;
  logic [WIDTH:0]   fifo_head;

  // The shift register always emits from its MSB, so a right-shifting word
  // is bit-reversed on load to send its LSB first.
  function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] d,
                                                  input logic left);
    logic [WIDTH-1:0] r;
    r = d;
    if (left != DIR_LEFT) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r[i] = d[WIDTH-1-i];
      end
    end
    return r;
  endfunction

  assign in_ready  = reset & ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  nibble_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({in_left, in_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ser_out_d   = ser_out_q;
    dir_out_d   = dir_out_q;
    busy_d      = busy_q;
    word_done_d = 1'b0;
    fifo_pop    = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ser_out_d = 1'b0;
        busy_d    = 1'b0;
        load      = ~fifo_empty;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST) begin
          // Last bit is on the wire now; chain straight into the next word.
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            ser_out_d = 1'b0;
            busy_d    = 1'b0;
          end
        end else begin
          cnt_d       = cnt_q + 1'b1;
          shreg_d     = shreg_q << 1;
          ser_out_d   = shreg_d[WIDTH-1];
          word_done_d = (cnt_d == LAST);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      fifo_pop    = 1'b1;
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      shreg_d     = order_bits(fifo_head[WIDTH-1:0], fifo_head[WIDTH]);
      ser_out_d   = shreg_d[WIDTH-1];
      dir_out_d   = fifo_head[WIDTH];
      busy_d      = 1'b1;
      word_done_d = (LAST == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_out_q   <= 1'b0;
      dir_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      dir_out_q   <= dir_out_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign dir_out   = dir_out_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_nibble_serializer.sv
module tb_nibble_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_left = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, ser_out, dir_out, busy, word_done;

  nibble_serializer #(.WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_left   (in_left),
    .ser_out   (ser_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted word occupies the serial line for 4 consecutive cycles,
  // starting one cycle after acceptance or right after the previous word.
  typedef struct {
    int         acc;
    int         start;
    logic [3:0] data;
    logic       left;
  } ent_t;

  ent_t       sched[$];
  int         cyc = 0;
  int         last_end = -10;
  logic       m_dir = 1'b0;
  logic       m_acc_last = 1'b0;
  logic [3:0] sipo_q = '0;
  logic       chk_pend = 1'b0;
  logic [3:0] chk_word = '0;

  function automatic int occ_at(input int c);
    int n = 0;
    foreach (sched[i]) if (sched[i].acc <= c && sched[i].start > c) n++;
    return n;
  endfunction

  always @(posedge clk) begin : model
    logic acc_now;
    ent_t e;
    acc_now = in_valid && reset && (occ_at(cyc) < 2);
    // downstream SIPO driven by the DUT
    sipo_q = dir_out ? {sipo_q[2:0], ser_out} : {ser_out, sipo_q[3:1]};
    foreach (sched[i]) begin
      if (sched[i].start + 3 == cyc) begin
        chk_pend = 1'b1;
        chk_word = sched[i].data;
      end
    end
    cyc++;
    m_acc_last = 1'b0;
    if (!reset) begin
      sched.delete();
      last_end = -10;
      m_dir    = 1'b0;
    end else begin
      if (acc_now) begin
        e.acc   = cyc;
        e.start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        e.data  = in_data;
        e.left  = in_left;
        sched.push_back(e);
        last_end   = e.start + 3;
        m_acc_last = 1'b1;
      end
      foreach (sched[i]) if (sched[i].start == cyc) m_dir = sched[i].left;
      while (sched.size() > 0 && sched[0].start + 3 < cyc) void'(sched.pop_front());
    end
  end

  // single compare process
  always @(negedge clk) begin : compare
    logic e_ser, e_busy, e_done;
    int idx;
    if (cyc > 0) begin
      e_ser = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      foreach (sched[i]) begin
        if (sched[i].start <= cyc && cyc <= sched[i].start + 3) begin
          idx    = cyc - sched[i].start;
          e_ser  = sched[i].left ? sched[i].data[3-idx] : sched[i].data[idx];
          e_busy = 1'b1;
          e_done = (idx == 3);
        end
      end
      check("ser_out", ser_out, e_ser);
      check("dir_out", dir_out, m_dir);
      check("busy", busy, e_busy);
      check("word_done", word_done, e_done);
      check("in_ready", in_ready, reset && (occ_at(cyc) < 2));
      if (chk_pend) begin
        check("sipo_q", sipo_q, chk_word);
        chk_pend = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic offer(input logic [3:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_left = l;
    forever begin
      @(posedge clk); #2;
      if (m_acc_last) break;
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Pins the model: word offered, accepted at edge N, checked bit by bit.
  task automatic send_one(input logic [3:0] d, input logic l, input logic [3:0] seq);
    offer(d, l);
    in_valid = 1'b0;
    @(negedge clk);  // cycle N: still idle
    check("lit_idle_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_ser", ser_out, seq[3-i]);
      check("lit_dir", dir_out, l);
      check("lit_done", word_done, (i == 3));
    end
    @(negedge clk);
    check("lit_sipo", sipo_q, d);
    @(posedge clk); #2;
  endtask

  logic [3:0] bw [4];
  logic       bl [4];

  initial begin
    // reset held 3 cycles with a word offered
    reset = 1'b0; in_valid = 1'b1; in_data = 4'hA; in_left = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ser", ser_out, 1'b0);
    check("rst_dir", dir_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", word_done, 1'b0);
    @(posedge clk); #2;
    in_valid = 1'b0; reset = 1'b1;
    idle(2);
    check("rst_no_word", busy, 1'b0);

    send_one(4'b1011, 1'b1, 4'b1011);
    send_one(4'b0110, 1'b0, 4'b0110);

    // streaming burst, valid held high
    bw[0] = 4'h1; bl[0] = 1'b1;
    bw[1] = 4'h8; bl[1] = 1'b0;
    bw[2] = 4'hF; bl[2] = 1'b1;
    bw[3] = 4'h5; bl[3] = 1'b0;
    for (int i = 0; i < 4; i++) offer(bw[i], bl[i]);
    idle(12);

    // reset during 2nd bit of a word with one more buffered
    offer(4'hC, 1'b1);
    offer(4'h3, 1'b0);
    in_valid = 1'b0;            // cycle N+1: bit0 of 0xC
    @(posedge clk); #2;         // cycle N+2: bit1
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);             // cycle N+3: after reset edge
    check("abort_busy", busy, 1'b0);
    check("abort_ser", ser_out, 1'b0);
    check("abort_done", word_done, 1'b0);
    check("abort_dir", dir_out, 1'b0);
    check("abort_ready", in_ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_never_sent", busy, 1'b0);
    end
    @(posedge clk); #2;

    // random traffic
    for (int i = 0; i < 32; i++) begin
      idle($urandom_range(0, 3));
      offer(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle(16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
